// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared types and helpers for the linear-probing hash table
package hash_table_pkg;

    typedef enum logic [1:0] {
        HOP_INSERT = 2'd0,
        HOP_LOOKUP = 2'd1,
        HOP_DELETE = 2'd2
    } hash_op_t;

    typedef enum logic [2:0] {
        HIT      = 3'd0,
        MISS     = 3'd1,
        INSERTED = 3'd2,
        UPDATED  = 3'd3,
        DELETED  = 3'd4,
        FULL     = 3'd5
    } hash_status_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        VALID = 2'd1,
        TOMB  = 2'd2
    } slot_state_t;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_CHK  = 3'd3,
        S_WR   = 3'd4,
        S_RESP = 3'd5
    } probe_fsm_t;

    // Width of one stored slot: 2-bit state tag, key tag, value.
    function automatic int slot_width(input int key_w, input int val_w);
        return 2 + key_w + val_w;
    endfunction

endpackage

// File: rtl/hash_table_probe_bram.sv
// rtl/hash_table_probe_bram.sv - single-port RAM with registered (1-cycle) read, read-first
module hash_table_probe_bram #(
    parameter int DATA_W = 50,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write on we; the read port always returns the pre-write contents one cycle later.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hash_table_probe.sv
// rtl/hash_table_probe.sv - linear-probing key/value table; HASH_TABLE_PROBE_STATS_EN adds occupancy_o/probe_hwm_o
module hash_table_probe
    import hash_table_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 32,
    parameter int ADDR_W    = 12,
    parameter int MAX_PROBE = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_done_o,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  hash_op_t           req_op_i,
    input  logic [ADDR_W-1:0]  req_idx_i,
    input  logic [KEY_W-1:0]   req_key_i,
    input  logic [VAL_W-1:0]   req_val_i,
    output logic               resp_valid_o,
    output hash_status_t       resp_status_o,
    output logic [VAL_W-1:0]   resp_val_o
`ifdef HASH_TABLE_PROBE_STATS_EN
    ,
    output logic [ADDR_W:0]                  occupancy_o,
    output logic [$clog2(MAX_PROBE+1)-1:0]   probe_hwm_o
`endif
);

    localparam int SLOT_W = slot_width(KEY_W, VAL_W);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(MAX_PROBE + 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_PROBE = CNT_W'(MAX_PROBE - 1);

    typedef struct packed {
        slot_state_t      state;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } slot_t;

    probe_fsm_t         state, state_nxt;
    logic [ADDR_W-1:0]  init_ptr, ptr, tomb_idx, wr_idx;
    logic               tomb_seen;
    logic [CNT_W-1:0]   count;
    hash_op_t           op_q;
    logic [KEY_W-1:0]   key_q;
    logic [VAL_W-1:0]   val_q;
    slot_t              wr_slot;
    hash_status_t       pend_status;
    logic [VAL_W-1:0]   pend_val;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    slot_t              mem_wdata;
    logic [SLOT_W-1:0]  mem_rdata;
    slot_t              rd_slot;

    logic               hit, last_probe, tomb_any;
    logic [ADDR_W-1:0]  tomb_at;
    logic               chk_resp, chk_wr, chk_adv, chk_tomb;
    hash_status_t       chk_status;
    logic [VAL_W-1:0]   chk_val;
    logic [ADDR_W-1:0]  chk_wr_idx;
    slot_t              chk_wr_slot;

    hash_table_probe_bram #(
        .DATA_W (SLOT_W),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rd_slot     = slot_t'(mem_rdata);
    assign req_ready_o = (state == S_IDLE);
    assign hit         = (rd_slot.state == VALID) && (rd_slot.key == key_q);
    assign last_probe  = (count == LAST_PROBE);
    // The slot under inspection counts as a reusable tomb when none was seen earlier.
    assign tomb_any    = tomb_seen || (rd_slot.state == TOMB);
    assign tomb_at     = tomb_seen ? tomb_idx : ptr;

    // State register; reset always restarts the clearing sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, RAM port steering and the per-probe decision.
    always_comb begin
        state_nxt   = state;
        mem_we      = 1'b0;
        mem_addr    = ptr;
        mem_wdata   = '{state: EMPTY, key: '0, val: '0};
        chk_resp    = 1'b0;
        chk_wr      = 1'b0;
        chk_adv     = 1'b0;
        chk_tomb    = 1'b0;
        chk_status  = MISS;
        chk_val     = '0;
        chk_wr_idx  = ptr;
        chk_wr_slot = '{state: VALID, key: key_q, val: val_q};
        case (state)
            S_INIT: begin
                mem_we   = 1'b1;
                mem_addr = init_ptr;
                if (init_ptr == LAST_SLOT) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid_i) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                state_nxt = S_CHK;
            end
            S_CHK: begin
                if (hit) begin
                    case (op_q)
                        HOP_LOOKUP: begin
                            chk_resp   = 1'b1;
                            chk_status = HIT;
                            chk_val    = rd_slot.val;
                        end
                        HOP_DELETE: begin
                            chk_wr      = 1'b1;
                            chk_status  = DELETED;
                            chk_wr_slot = '{state: TOMB, key: rd_slot.key, val: rd_slot.val};
                        end
                        default: begin
                            chk_wr     = 1'b1;
                            chk_status = UPDATED;
                            chk_val    = rd_slot.val;
                        end
                    endcase
                end else if (rd_slot.state == EMPTY) begin
                    // An empty slot terminates the chain: the key cannot live further on.
                    if (op_q == HOP_INSERT) begin
                        chk_wr     = 1'b1;
                        chk_status = INSERTED;
                        chk_wr_idx = tomb_at;
                    end else begin
                        chk_resp = 1'b1;
                    end
                end else begin
                    chk_tomb = (rd_slot.state == TOMB) && !tomb_seen;
                    if (last_probe) begin
                        if (op_q != HOP_INSERT) begin
                            chk_resp = 1'b1;
                        end else if (tomb_any) begin
                            chk_wr     = 1'b1;
                            chk_status = INSERTED;
                            chk_wr_idx = tomb_at;
                        end else begin
                            chk_resp   = 1'b1;
                            chk_status = FULL;
                        end
                    end else begin
                        chk_adv = 1'b1;
                    end
                end
                state_nxt = chk_wr ? S_WR : (chk_resp ? S_RESP : S_RD);
            end
            S_WR: begin
                mem_we    = 1'b1;
                mem_addr  = wr_idx;
                mem_wdata = wr_slot;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Request latch, probe pointer/count, first-tomb tracking, pending write and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_ptr      <= '0;
            init_done_o   <= 1'b0;
            ptr           <= '0;
            count         <= '0;
            tomb_seen     <= 1'b0;
            tomb_idx      <= '0;
            wr_idx        <= '0;
            wr_slot       <= '{state: EMPTY, key: '0, val: '0};
            op_q          <= HOP_LOOKUP;
            key_q         <= '0;
            val_q         <= '0;
            pend_status   <= MISS;
            pend_val      <= '0;
            resp_valid_o  <= 1'b0;
            resp_status_o <= MISS;
            resp_val_o    <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            if (state == S_INIT) begin
                init_ptr <= init_ptr + ADDR_W'(1);
                if (init_ptr == LAST_SLOT) begin
                    init_done_o <= 1'b1;
                end
            end
            if (state == S_IDLE && req_valid_i) begin
                op_q      <= req_op_i;
                key_q     <= req_key_i;
                val_q     <= req_val_i;
                ptr       <= req_idx_i;
                count     <= '0;
                tomb_seen <= 1'b0;
            end
            if (state == S_CHK) begin
                if (chk_tomb) begin
                    tomb_seen <= 1'b1;
                    tomb_idx  <= ptr;
                end
                if (chk_adv) begin
                    ptr   <= ptr + ADDR_W'(1);
                    count <= count + CNT_W'(1);
                end
                if (chk_wr) begin
                    wr_idx      <= chk_wr_idx;
                    wr_slot     <= chk_wr_slot;
                    pend_status <= chk_status;
                    pend_val    <= chk_val;
                end
                if (chk_resp) begin
                    resp_valid_o  <= 1'b1;
                    resp_status_o <= chk_status;
                    resp_val_o    <= chk_val;
                end
            end
            if (state == S_WR) begin
                resp_valid_o  <= 1'b1;
                resp_status_o <= pend_status;
                resp_val_o    <= pend_val;
            end
        end
    end

`ifdef HASH_TABLE_PROBE_STATS_EN
    logic [CNT_W-1:0] probes;
    assign probes = count + CNT_W'(1);

    // Live-slot count follows committed inserts/deletes; high-water mark of slots examined per request.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_o <= '0;
            probe_hwm_o <= '0;
        end else begin
            if (state == S_INIT) begin
                occupancy_o <= '0;
            end else if (state == S_WR && pend_status == INSERTED) begin
                occupancy_o <= occupancy_o + (ADDR_W+1)'(1);
            end else if (state == S_WR && pend_status == DELETED) begin
                occupancy_o <= occupancy_o - (ADDR_W+1)'(1);
            end
            if ((state == S_CHK && chk_resp) || state == S_WR) begin
                if (probes > probe_hwm_o) begin
                    probe_hwm_o <= probes;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_hash_table_probe.sv
// tb/tb_hash_table_probe.sv - self-checking bench for hash_table_probe (DEPTH 16, MAX_PROBE 4)
module tb_hash_table_probe;
    import hash_table_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    hash_op_t      req_op;
    logic [3:0]    req_idx;
    logic [15:0]   req_key;
    logic [31:0]   req_val;
    logic          resp_valid;
    hash_status_t  resp_status;
    logic [31:0]   resp_val;
`ifdef HASH_TABLE_PROBE_STATS_EN
    logic [4:0]    occupancy;
    logic [2:0]    probe_hwm;
`endif

    hash_table_probe #(
        .KEY_W     (16),
        .VAL_W     (32),
        .ADDR_W    (4),
        .MAX_PROBE (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done_o   (init_done),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_idx_i     (req_idx),
        .req_key_i     (req_key),
        .req_val_i     (req_val),
        .resp_valid_o  (resp_valid),
        .resp_status_o (resp_status),
        .resp_val_o    (resp_val)
`ifdef HASH_TABLE_PROBE_STATS_EN
        ,
        .occupancy_o   (occupancy),
        .probe_hwm_o   (probe_hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        hash_op_t     op;
        logic [3:0]   idx;
        logic [15:0]  key;
        logic [31:0]  val;
        hash_status_t st;
        logic [31:0]  rv;
        int           lat;
    } vec_t;

    typedef struct {
        hash_status_t st;
        logic [31:0]  rv;
        int           lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input hash_op_t op, input logic [3:0] idx, input logic [15:0] key,
                                input logic [31:0] val, input hash_status_t st, input logic [31:0] rv,
                                input int lat);
        vec_t v;
        v.op = op; v.idx = idx; v.key = key; v.val = val; v.st = st; v.rv = rv; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, push its expectation, then pop and compare when the response pulse arrives.
    task automatic do_req(input string tag, input hash_op_t op, input logic [3:0] idx, input logic [15:0] key,
                          input logic [31:0] val, input hash_status_t est, input logic [31:0] ev, input int elat);
        exp_t e;
        exp_t got;
        int   guard;
        int   lat;
        bit   seen;
        e.st = est; e.rv = ev; e.lat = elat;
        sb.push_back(e);
        req_op = op; req_idx = idx; req_key = key; req_val = val; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            got = sb.pop_front();
            chk($sformatf("%s_ready_timeout", tag), 64'(req_ready), 64'(1));
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        got = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no response in 40 cycles, expected status %0d", tag, got.st);
        end else begin
            chk($sformatf("%s_status", tag), 64'(resp_status), 64'(got.st));
            chk($sformatf("%s_val", tag), 64'(resp_val), 64'(got.rv));
            chk($sformatf("%s_latency", tag), 64'(lat), 64'(got.lat));
            @(posedge clk); #1;
            chk($sformatf("%s_pulse", tag), 64'(resp_valid), 64'(0));
            chk($sformatf("%s_ready_after", tag), 64'(req_ready), 64'(1));
        end
    endtask

    // Release reset and follow the clearing sweep: 16 cycles not ready, then ready and init_done.
    task automatic init_seq(input string tag);
        int busy_ready;
        int stray_resp;
        busy_ready = 0;
        stray_resp = 0;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (req_ready || init_done) busy_ready++;
            if (resp_valid) stray_resp++;
            @(posedge clk); #1;
        end
        chk($sformatf("%s_ready_low_cycles", tag), 64'(busy_ready), 64'(0));
        chk($sformatf("%s_no_resp", tag), 64'(stray_resp), 64'(0));
        chk($sformatf("%s_ready", tag), 64'(req_ready), 64'(1));
        chk($sformatf("%s_done", tag), 64'(init_done), 64'(1));
    endtask

    initial begin
        bit saw;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = HOP_LOOKUP;
        req_idx = '0;
        req_key = '0;
        req_val = '0;

        vecs.push_back(mk(HOP_INSERT, 4'd3,  16'h0012, 32'hDEADBEEF, INSERTED, 32'h0,        3));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0012, 32'h0,        HIT,      32'hDEADBEEF, 2));
        vecs.push_back(mk(HOP_INSERT, 4'd3,  16'h0022, 32'h1,        INSERTED, 32'h0,        5));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0022, 32'h0,        HIT,      32'h1,        4));
        vecs.push_back(mk(HOP_INSERT, 4'd3,  16'h0012, 32'hCAFE,     UPDATED,  32'hDEADBEEF, 3));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0012, 32'h0,        HIT,      32'hCAFE,     2));
        vecs.push_back(mk(HOP_DELETE, 4'd3,  16'h0012, 32'h0,        DELETED,  32'h0,        3));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0022, 32'h0,        HIT,      32'h1,        4));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0012, 32'h0,        MISS,     32'h0,        6));
        vecs.push_back(mk(HOP_DELETE, 4'd3,  16'h0012, 32'h0,        MISS,     32'h0,        6));
        vecs.push_back(mk(HOP_INSERT, 4'd3,  16'h0033, 32'h33,       INSERTED, 32'h0,        7));
        vecs.push_back(mk(HOP_LOOKUP, 4'd3,  16'h0033, 32'h0,        HIT,      32'h33,       2));
        vecs.push_back(mk(HOP_INSERT, 4'd15, 16'h0100, 32'hA0,       INSERTED, 32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd0,  16'h0101, 32'hA1,       INSERTED, 32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd1,  16'h0102, 32'hA2,       INSERTED, 32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd2,  16'h0103, 32'hA3,       INSERTED, 32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd15, 16'h0200, 32'h5,        FULL,     32'h0,        8));
        vecs.push_back(mk(HOP_LOOKUP, 4'd15, 16'h0103, 32'h0,        HIT,      32'hA3,       8));
        vecs.push_back(mk(HOP_LOOKUP, 4'd15, 16'h0200, 32'h0,        MISS,     32'h0,        8));
        vecs.push_back(mk(HOP_DELETE, 4'd0,  16'h0101, 32'h0,        DELETED,  32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd15, 16'h0200, 32'hB0,       INSERTED, 32'h0,        9));
        vecs.push_back(mk(HOP_LOOKUP, 4'd15, 16'h0200, 32'h0,        HIT,      32'hB0,       4));
        vecs.push_back(mk(HOP_DELETE, 4'd2,  16'h0103, 32'h0,        DELETED,  32'h0,        3));
        vecs.push_back(mk(HOP_INSERT, 4'd15, 16'h0300, 32'hC0,       INSERTED, 32'h0,        9));
        vecs.push_back(mk(HOP_LOOKUP, 4'd15, 16'h0300, 32'h0,        HIT,      32'hC0,       8));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",       64'(req_ready),   64'(0));
        chk("reset_resp_valid",  64'(resp_valid),  64'(0));
        chk("reset_resp_status", 64'(resp_status), 64'(MISS));
        chk("reset_resp_val",    64'(resp_val),    64'(0));
        chk("reset_init_done",   64'(init_done),   64'(0));

        init_seq("init");

        for (int i = 0; i < vecs.size(); i++) begin
            do_req($sformatf("v%0d", i), vecs[i].op, vecs[i].idx, vecs[i].key, vecs[i].val,
                   vecs[i].st, vecs[i].rv, vecs[i].lat);
        end

`ifdef HASH_TABLE_PROBE_STATS_EN
        chk("stats_occupancy", 64'(occupancy), 64'(6));
        chk("stats_probe_hwm", 64'(probe_hwm), 64'(4));
`endif

        // Reset lands while an INSERT sits in its first check cycle.
        req_op = HOP_INSERT; req_idx = 4'd5; req_key = 16'h0400; req_val = 32'h7; req_valid = 1'b1;
        chk("midop_accept_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) saw = 1'b1;
        end
        chk("midop_no_resp",   64'(saw),       64'(0));
        chk("midop_ready_low", 64'(req_ready), 64'(0));
        chk("midop_init_done", 64'(init_done), 64'(0));

        init_seq("reinit");

`ifdef HASH_TABLE_PROBE_STATS_EN
        chk("stats_occupancy_cleared", 64'(occupancy), 64'(0));
`endif

        do_req("post_k33",  HOP_LOOKUP, 4'd3,  16'h0033, 32'h0, MISS, 32'h0, 2);
        do_req("post_k22",  HOP_LOOKUP, 4'd3,  16'h0022, 32'h0, MISS, 32'h0, 2);
        do_req("post_k100", HOP_LOOKUP, 4'd15, 16'h0100, 32'h0, MISS, 32'h0, 2);
        do_req("post_k200", HOP_LOOKUP, 4'd0,  16'h0200, 32'h0, MISS, 32'h0, 2);
        do_req("post_k400", HOP_LOOKUP, 4'd5,  16'h0400, 32'h0, MISS, 32'h0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
